sym_fir_mc_pipe: RTL

SYM_FIR_MC_PIPE -- requirements
Module: sym_fir_mc_pipe

---
 rtl/sym_fir_mc_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/sym_fir_mc_pipe.sv
// sym_fir_mc_pipe: multichannel symmetric FIR with per-channel delay lines and a 3-stage pipeline
// Ports: clk/arst_n clock and async active-low reset; clear flushes state synchronously;
//        data_in/ch_in/valid_in/ready_in sample input; data_out/ch_out/valid_out/ready_out result output.
module sym_fir_mc_pipe #(
    parameter int INPUT_WORD_SIZE = 16,
    parameter int COEFF_WORD_SIZE = 5,
    parameter int N_TAPS = 5,
    parameter int N_CHANNELS = 1,
    parameter logic [((N_TAPS + 1) / 2) * COEFF_WORD_SIZE - 1:0] COEFFS = {5'd3, 5'd2, 5'd1},
    parameter int OUT_SHIFT = 0,
    parameter int OUT_WORD_SIZE = INPUT_WORD_SIZE + 1 + COEFF_WORD_SIZE + $clog2((N_TAPS + 1) / 2) - OUT_SHIFT,
    localparam int CHW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic                            clear,
    input  logic signed [INPUT_WORD_SIZE-1:0] data_in,
    input  logic [CHW-1:0]                  ch_in,
    input  logic                            valid_in,
    output logic                            ready_in,
    output logic signed [OUT_WORD_SIZE-1:0] data_out,
    output logic [CHW-1:0]                  ch_out,
    output logic                            valid_out,
    input  logic                            ready_out
);
    localparam int NU = (N_TAPS + 1) / 2;
    localparam int IW = INPUT_WORD_SIZE;
    localparam int CW = COEFF_WORD_SIZE;
    localparam int PW = IW + 1;
    localparam int MW = PW + CW;
    localparam int FULL_W = MW + $clog2(NU);
    localparam int OW = OUT_WORD_SIZE;
    localparam int DL = N_TAPS - 1;
    // one guard bit above the full sum so the rounding add cannot wrap
    localparam int SW = (FULL_W + 1 > OW + 1) ? FULL_W + 1 : OW + 1;
    localparam int RS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [SW-1:0] RND = (OUT_SHIFT > 0) ? SW'(1) << RS : '0;
    localparam logic signed [SW-1:0] MAXV = {{(SW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [IW-1:0]     dl [N_CHANNELS][DL];
    logic signed [IW-1:0]     xs [N_TAPS];
    logic signed [CW-1:0]     h [NU];
    logic signed [PW-1:0]     pre_d [NU];
    logic signed [PW-1:0]     pre [NU];
    logic signed [MW-1:0]     prod [NU];
    logic                     v1, v2, ch_ok, adv, accept;
    logic [CHW-1:0]           c1, c2, ch_sel;
    logic signed [FULL_W-1:0] sum;
    logic signed [SW-1:0]     shifted, sat;

    assign ready_in = adv;

    always_comb begin
        ch_ok = {1'b0, ch_in} < (CHW + 1)'(N_CHANNELS);
        // out-of-range channels still need a legal index; their sample is dropped anyway
        ch_sel = ch_ok ? ch_in : '0;
        adv = ready_out | ~valid_out;
        accept = valid_in & adv & ch_ok & ~clear;
        xs[0] = data_in;
        for (int k = 1; k < N_TAPS; k++) xs[k] = dl[ch_sel][k-1];
        for (int i = 0; i < NU; i++) begin
            h[i] = COEFFS[i*CW +: CW];
            // the centre tap of an odd-length filter has no mirror partner
            pre_d[i] = (2 * i == N_TAPS - 1) ? PW'(xs[i]) : PW'(xs[i]) + PW'(xs[N_TAPS-1-i]);
        end
        sum = '0;
        for (int i = 0; i < NU; i++) sum = sum + FULL_W'(prod[i]);
        shifted = (SW'(sum) + RND) >>> OUT_SHIFT;
        sat = (shifted > MAXV) ? MAXV : (shifted < MINV) ? MINV : shifted;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < N_CHANNELS; c++) for (int k = 0; k < DL; k++) dl[c][k] <= '0;
            for (int i = 0; i < NU; i++) begin
                pre[i] <= '0;
                prod[i] <= '0;
            end
            {v1, v2, valid_out} <= '0;
            c1 <= '0;
            c2 <= '0;
            ch_out <= '0;
            data_out <= '0;
        end else if (clear) begin
            for (int c = 0; c < N_CHANNELS; c++) for (int k = 0; k < DL; k++) dl[c][k] <= '0;
            for (int i = 0; i < NU; i++) begin
                pre[i] <= '0;
                prod[i] <= '0;
            end
            {v1, v2, valid_out} <= '0;
            c1 <= '0;
            c2 <= '0;
            ch_out <= '0;
            data_out <= '0;
        end else if (adv) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (accept && CHW'(c) == ch_sel) begin
                    dl[c][0] <= data_in;
                    for (int k = 1; k < DL; k++) dl[c][k] <= dl[c][k-1];
                end
            end
            for (int i = 0; i < NU; i++) begin
                pre[i] <= pre_d[i];
                prod[i] <= MW'(pre[i]) * MW'(h[i]);
            end
            v1 <= accept;
            c1 <= ch_sel;
            v2 <= v1;
            c2 <= c1;
            valid_out <= v2;
            ch_out <= c2;
            data_out <= sat[OW-1:0];
        end
    end
endmodule
